// File: rtl/fifo_pkg.sv
// Shared types and defaults for the parametrised FIFO.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    // Per-cycle operation, decoded from the accepted write/read pair.
    typedef enum logic [1:0] {
        OP_IDLE,
        OP_WR,
        OP_RD,
        OP_RW
    } fifo_op_t;

    // Map {wr_ok, rd_ok} onto the operation used by the pointer/count update.
    function automatic fifo_op_t decode_op(input logic wr_ok, input logic rd_ok);
        fifo_op_t op;
        case ({wr_ok, rd_ok})
            2'b10:   op = OP_WR;
            2'b01:   op = OP_RD;
            2'b11:   op = OP_RW;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ram_dp.sv
// Storage array: one synchronous write port, one asynchronous read port.
module fifo_ram_dp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Write the addressed word on the clock edge when enabled.
    // NOTE: no reset on the array - clearing it would block RAM inference and
    // stale contents are never visible because the pointers define occupancy.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : fifo_ram_dp

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
// Build option: define FIFO_FWFT_EN for first-word-fall-through output;
// leave it undefined for registered-read output (one cycle latency).
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] inputBus,
    input  logic              clear_err,
    output logic [DATA_W-1:0] outputBus,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W+1)'(AE_THRESH);

    // Thresholds must leave a gap; otherwise both almost flags overlap.
    if (AE_THRESH >= AF_THRESH) begin : g_bad_thresh
        $error("fifo_param: AE_THRESH (%0d) must be below AF_THRESH (%0d)",
               AE_THRESH, AF_THRESH);
    end

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_almost_empty;
    logic              r_almost_full;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_ovf_evt;
    logic              w_udf_evt;
    fifo_op_t          w_op;
    logic [ADDR_W-1:0] w_wr_ptr_next;
    logic [ADDR_W-1:0] w_rd_ptr_next;
    logic [ADDR_W:0]   w_count_next;
    logic [DATA_W-1:0] w_rd_data;

    // Accept rules use pre-edge flags; a full FIFO still takes a write when it
    // is also being read in the same cycle.
    assign w_wr_ok   = write & (~r_full | read);
    assign w_rd_ok   = read & ~r_empty;
    assign w_ovf_evt = write & r_full & ~read;
    assign w_udf_evt = read & r_empty;
    assign w_op      = decode_op(w_wr_ok, w_rd_ok);

    fifo_ram_dp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (inputBus),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Next pointers and count; pointers wrap naturally at 2**ADDR_W.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        case (w_op)
            OP_WR: begin
                w_wr_ptr_next = r_wr_ptr + 1'b1;
                w_count_next  = r_count + 1'b1;
            end
            OP_RD: begin
                w_rd_ptr_next = r_rd_ptr + 1'b1;
                w_count_next  = r_count - 1'b1;
            end
            OP_RW: begin
                w_wr_ptr_next = r_wr_ptr + 1'b1;
                w_rd_ptr_next = r_rd_ptr + 1'b1;
            end
            default: ;
        endcase
    end

    // Pointer, count and status flag registers; flags derive from the next count.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_next;
            r_rd_ptr       <= w_rd_ptr_next;
            r_count        <= w_count_next;
            r_empty        <= (w_count_next == '0);
            r_full         <= (w_count_next == DEPTH_CNT);
            r_almost_empty <= (w_count_next <= AE_CNT);
            r_almost_full  <= (w_count_next >= AF_CNT);
        end
    end

    // Sticky error flags: a new error in the clear cycle wins over the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  & ~clear_err) | w_ovf_evt;
            r_underflow <= (r_underflow & ~clear_err) | w_udf_evt;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; zero while nothing is stored.
    always_comb begin
        outputBus = r_empty ? '0 : w_rd_data;
    end
`else
    logic [DATA_W-1:0] r_out;

    // Capture the head word on an accepted read; hold it otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
        end else if (w_rd_ok) begin
            r_out <= w_rd_data;
        end
    end

    assign outputBus = r_out;
`endif

    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_almost_empty;
    assign almost_full  = r_almost_full;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule : fifo_param

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param in registered-read mode
// (depth 4, almost_full at 3, almost_empty at 1).
module tb_fifo_param;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 2;
    localparam int AF_THRESH = 3;
    localparam int AE_THRESH = 1;

    logic              clk;
    logic              reset_n;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] inputBus;
    logic              clear_err;
    logic [DATA_W-1:0] outputBus;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_param #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .AF_THRESH (AF_THRESH),
        .AE_THRESH (AE_THRESH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .read         (read),
        .write        (write),
        .inputBus     (inputBus),
        .clear_err    (clear_err),
        .outputBus    (outputBus),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the edge.
    task automatic step(input logic wr, input logic rd, input logic [DATA_W-1:0] d,
                        input logic clr);
        write     = wr;
        read      = rd;
        inputBus  = d;
        clear_err = clr;
        @(posedge clk);
        #1;
        write     = 1'b0;
        read      = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic check_status(input string tag, input int c, input logic e,
                                input logic f, input logic ae, input logic af);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".empty"}, 32'(empty), 32'(e));
        check({tag, ".full"},  32'(full),  32'(f));
        check({tag, ".ae"},    32'(almost_empty), 32'(ae));
        check({tag, ".af"},    32'(almost_full),  32'(af));
    endtask

    initial begin
        reset_n   = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        inputBus  = '0;
        clear_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // 1: reset state
        check_status("rst", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("rst.out", 32'(outputBus), 32'h00);
        check("rst.ovf", 32'(overflow), 0);
        check("rst.udf", 32'(underflow), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // 2: fill to full, then overflow
        step(1, 0, 8'h11, 0); check_status("w1", 1, 0, 0, 1, 0);
        step(1, 0, 8'h22, 0); check_status("w2", 2, 0, 0, 0, 0);
        step(1, 0, 8'h33, 0); check_status("w3", 3, 0, 0, 0, 1);
        step(1, 0, 8'h44, 0); check_status("w4", 4, 0, 1, 0, 1);
        check("w4.ovf", 32'(overflow), 0);
        step(1, 0, 8'h55, 0); check_status("w5", 4, 0, 1, 0, 1);
        check("w5.ovf", 32'(overflow), 1);

        // 3: drain in order, then underflow with output held
        step(0, 1, 8'h00, 0); check("r1.out", 32'(outputBus), 32'h11); check("r1.cnt", 32'(count), 3);
        step(0, 1, 8'h00, 0); check("r2.out", 32'(outputBus), 32'h22);
        step(0, 1, 8'h00, 0); check("r3.out", 32'(outputBus), 32'h33);
        step(0, 1, 8'h00, 0); check("r4.out", 32'(outputBus), 32'h44);
        check_status("r4", 0, 1, 0, 1, 0);
        check("r4.udf", 32'(underflow), 0);
        step(0, 1, 8'h00, 0);
        check("r5.udf", 32'(underflow), 1);
        check("r5.out", 32'(outputBus), 32'h44);
        check("r5.ovf", 32'(overflow), 1);
        step(0, 0, 8'h00, 1);
        check("clr.ovf", 32'(overflow), 0);
        check("clr.udf", 32'(underflow), 0);

        // 4: simultaneous read+write while full, then drain across the wrap
        step(1, 0, 8'h11, 0);
        step(1, 0, 8'h22, 0);
        step(1, 0, 8'h33, 0);
        step(1, 0, 8'h44, 0);
        step(1, 1, 8'h66, 0);
        check_status("rwf", 4, 0, 1, 0, 1);
        check("rwf.ovf", 32'(overflow), 0);
        check("rwf.out", 32'(outputBus), 32'h11);
        step(0, 1, 8'h00, 0); check("d1.out", 32'(outputBus), 32'h22);
        step(0, 1, 8'h00, 0); check("d2.out", 32'(outputBus), 32'h33);
        step(0, 1, 8'h00, 0); check("d3.out", 32'(outputBus), 32'h44);
        step(0, 1, 8'h00, 0); check("d4.out", 32'(outputBus), 32'h66);
        check("d4.empty", 32'(empty), 1);

        // 5: simultaneous read+write while empty; clear; clear vs new error
        step(1, 1, 8'h77, 0);
        check_status("rwe", 1, 0, 0, 1, 0);
        check("rwe.udf", 32'(underflow), 1);
        check("rwe.out", 32'(outputBus), 32'h66);
        step(0, 0, 8'h00, 1);
        check("rwe.clr", 32'(underflow), 0);
        step(0, 1, 8'h00, 0);
        check("rwe.rd", 32'(outputBus), 32'h77);
        check("rwe.rd.udf", 32'(underflow), 0);
        step(0, 1, 8'h00, 1);
        check("setwins.udf", 32'(underflow), 1);

        // 6: reset asserted mid-fill discards stored words immediately
        step(0, 0, 8'h00, 1);
        step(1, 0, 8'hA5, 0);
        step(1, 0, 8'hB6, 0);
        step(0, 1, 8'h00, 0);
        check("pre.out", 32'(outputBus), 32'hA5);
        reset_n = 1'b0;
        #1;
        check_status("mid", 0, 1, 0, 1, 0);
        check("mid.out", 32'(outputBus), 32'h00);
        check("mid.udf", 32'(underflow), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        step(1, 0, 8'hC7, 0);
        step(0, 1, 8'h00, 0);
        check("post.out", 32'(outputBus), 32'hC7);
        check("post.empty", 32'(empty), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fifo_param
